led_zone_serializer: RTL and testbench

Read-side consumer of the zone-mean FIFO in the local-dimming path. One frame is 40 packed 24-bit RGB zone means, written into the FIFO by the write-side port logic. This block drains exactly one frame per `frame_start` and reduces each zone to an 8-bit backlight duty. It shifts the duties MSB-first to the LED driver chain over a clock/data/latch serial link, then latches them.

---
 rtl/led_pkg.sv | 34 +++
 rtl/led_gamma_lut.sv | 19 +
 rtl/led_zone_serializer.sv | 192 +++++++++++++++++++
 tb/tb_led_zone_serializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED zone serializer: FSM states, default zone
// count, packed RGB channel positions and the duty width.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LATCH = 3'd4,
        ST_DONE  = 3'd5
    } led_state_e;

    localparam int LED_ZONE_NUM = 40;
    localparam int DUTY_W       = 8;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // Unsigned maximum of the three 8-bit colour channels.
    function automatic logic [DUTY_W-1:0] max3(input logic [DUTY_W-1:0] r,
                                               input logic [DUTY_W-1:0] g,
                                               input logic [DUTY_W-1:0] b);
        logic [DUTY_W-1:0] m;
        m = (r > g) ? r : g;
        m = (b > m) ? b : m;
        return m;
    endfunction

endpackage

// File: rtl/led_gamma_lut.sv
// Gamma-2.2 correction ROM: y = round(255 * (x/255)^2.2), 256 constant entries.
// Only instantiated when LED_GAMMA_EN is defined.
module led_gamma_lut
    import led_pkg::*;
(
    input  logic [DUTY_W-1:0] x,
    output logic [DUTY_W-1:0] y
);

    logic [DUTY_W-1:0] rom_s [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        localparam int V = int'(255.0 * $pow(real'(i) / 255.0, 2.2));
        assign rom_s[i] = DUTY_W'(V);
    end

    assign y = rom_s[x];

endmodule

// File: rtl/led_zone_serializer.sv
// Drains one frame of zone means from the FIFO, reduces each to an 8-bit duty
// and shifts it MSB-first to the LED driver chain. Optional: LED_GAMMA_EN.
module led_zone_serializer
    import led_pkg::*;
#(
    parameter int ZONE_NUM     = LED_ZONE_NUM,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic        rd_clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic        led_sclk,
    output logic        led_sdo,
    output logic        led_latch,
    output logic        busy,
    output logic        frame_done,
    output logic        underflow
);

    localparam int ZW = (ZONE_NUM > 1)     ? $clog2(ZONE_NUM)     : 1;
    localparam int WW = (TIMEOUT > 1)      ? $clog2(TIMEOUT)      : 1;
    localparam int DW = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    led_state_e        state_r,  state_nx_s;
    logic [ZW-1:0]     zone_r,   zone_nx_s;
    logic [WW-1:0]     wait_r,   wait_nx_s;
    logic [2:0]        bit_r,    bit_nx_s;
    logic [DW-1:0]     div_r,    div_nx_s;
    logic              half_r,   half_nx_s;
    logic [LW-1:0]     lat_r,    lat_nx_s;
    logic [DUTY_W-1:0] duty_r,   duty_nx_s;
    logic              underflow_nx_s;

    logic [DUTY_W-1:0] max_s;
    logic [DUTY_W-1:0] duty_src_s;

    logic led_sclk_r, led_sdo_r, led_latch_r, busy_r, frame_done_r, underflow_r;

    assign max_s = max3(fifo_dout[R_MSB:R_LSB], fifo_dout[G_MSB:G_LSB], fifo_dout[B_MSB:B_LSB]);

`ifdef LED_GAMMA_EN
    led_gamma_lut u_gamma (
        .x (max_s),
        .y (duty_src_s)
    );
`else
    assign duty_src_s = max_s;
`endif

    // The FIFO strobe must reach the FIFO in the same cycle, so it is not registered.
    assign fifo_rd_en = (state_r == ST_FETCH) && !fifo_empty;

    // Next-state and counter logic for the frame sequencer.
    always_comb begin
        state_nx_s     = state_r;
        zone_nx_s      = zone_r;
        wait_nx_s      = wait_r;
        bit_nx_s       = bit_r;
        div_nx_s       = div_r;
        half_nx_s      = half_r;
        lat_nx_s       = lat_r;
        duty_nx_s      = duty_r;
        underflow_nx_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nx_s = ST_FETCH;
                    zone_nx_s  = ZW'(0);
                    wait_nx_s  = WW'(0);
                    bit_nx_s   = 3'd0;
                    div_nx_s   = DW'(0);
                    half_nx_s  = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    state_nx_s = ST_WAIT;
                    wait_nx_s  = WW'(0);
                end else if (wait_r == WW'(TIMEOUT - 1)) begin
                    state_nx_s     = ST_IDLE;
                    wait_nx_s      = WW'(0);
                    underflow_nx_s = 1'b1;
                end else begin
                    wait_nx_s = wait_r + WW'(1);
                end
            end
            ST_WAIT: begin
                duty_nx_s  = duty_src_s;
                bit_nx_s   = 3'd0;
                div_nx_s   = DW'(0);
                half_nx_s  = 1'b0;
                state_nx_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_r == DW'(CLK_DIV - 1)) begin
                    div_nx_s = DW'(0);
                    if (!half_r) begin
                        half_nx_s = 1'b1;
                    end else begin
                        half_nx_s = 1'b0;
                        if (bit_r == 3'd7) begin
                            bit_nx_s = 3'd0;
                            if (zone_r == ZW'(ZONE_NUM - 1)) begin
                                state_nx_s = ST_LATCH;
                                lat_nx_s   = LW'(0);
                            end else begin
                                state_nx_s = ST_FETCH;
                                zone_nx_s  = zone_r + ZW'(1);
                            end
                        end else begin
                            bit_nx_s = bit_r + 3'd1;
                        end
                    end
                end else begin
                    div_nx_s = div_r + DW'(1);
                end
            end
            ST_LATCH: begin
                if (lat_r == LW'(LATCH_CYCLES - 1)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    lat_nx_s = lat_r + LW'(1);
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            zone_r  <= ZW'(0);
            wait_r  <= WW'(0);
            bit_r   <= 3'd0;
            div_r   <= DW'(0);
            half_r  <= 1'b0;
            lat_r   <= LW'(0);
            duty_r  <= DUTY_W'(0);
        end else begin
            state_r <= state_nx_s;
            zone_r  <= zone_nx_s;
            wait_r  <= wait_nx_s;
            bit_r   <= bit_nx_s;
            div_r   <= div_nx_s;
            half_r  <= half_nx_s;
            lat_r   <= lat_nx_s;
            duty_r  <= duty_nx_s;
        end
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            led_sclk_r   <= 1'b0;
            led_sdo_r    <= 1'b0;
            led_latch_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            led_sclk_r   <= (state_nx_s == ST_SHIFT) && half_nx_s;
            led_sdo_r    <= (state_nx_s == ST_SHIFT) ? duty_nx_s[3'd7 - bit_nx_s] : 1'b0;
            led_latch_r  <= (state_nx_s == ST_LATCH);
            busy_r       <= (state_nx_s != ST_IDLE);
            frame_done_r <= (state_nx_s == ST_DONE);
            underflow_r  <= underflow_nx_s;
        end
    end

    assign led_sclk   = led_sclk_r;
    assign led_sdo    = led_sdo_r;
    assign led_latch  = led_latch_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_led_zone_serializer.sv
// Directed self-checking bench for led_zone_serializer with a behavioural FIFO
// and a serial-link monitor that decodes bytes on led_sclk rising edges.
module tb_led_zone_serializer;

    logic        rd_clk;
    logic        rst;
    logic        frame_start;
    logic        fifo_empty;
    logic [23:0] fifo_dout;
    logic        fifo_rd_en;
    logic        led_sclk;
    logic        led_sdo;
    logic        led_latch;
    logic        busy;
    logic        frame_done;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    led_zone_serializer dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .frame_start (frame_start),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .led_sclk    (led_sclk),
        .led_sdo     (led_sdo),
        .led_latch   (led_latch),
        .busy        (busy),
        .frame_done  (frame_done),
        .underflow   (underflow)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Behavioural FIFO, one-cycle read latency
    logic [23:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        stall;

    assign fifo_empty = stall || (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Link monitor, sampled on the falling clock edge
    int         cyc = 0;
    int         busy_rise = 0;
    int         done_cyc = 0;
    int         uf_cyc = 0;
    int         rd_cnt, rise_cnt, ones_cnt, latch_cnt, overlap_cnt, done_cnt, uf_cnt, nb;
    logic       busy_q = 1'b0;
    logic       sclk_q = 1'b0;
    logic [7:0] sh;
    logic [7:0] bytes_q[$];

    always @(negedge rd_clk) begin
        cyc = cyc + 1;
        if (busy && !busy_q) busy_rise = cyc;
        busy_q = busy;
        if (fifo_rd_en) rd_cnt = rd_cnt + 1;
        if (led_sclk && !sclk_q) begin
            rise_cnt = rise_cnt + 1;
            if (led_sdo) ones_cnt = ones_cnt + 1;
            sh = {sh[6:0], led_sdo};
            nb = nb + 1;
            if (nb % 8 == 0) bytes_q.push_back(sh);
        end
        sclk_q = led_sclk;
        if (led_latch) latch_cnt = latch_cnt + 1;
        if (led_latch && led_sclk) overlap_cnt = overlap_cnt + 1;
        if (frame_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if (underflow) begin uf_cnt = uf_cnt + 1; uf_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cnt = 0; rise_cnt = 0; ones_cnt = 0; latch_cnt = 0; overlap_cnt = 0;
        done_cnt = 0; uf_cnt = 0; nb = 0; sh = 8'h00;
        bytes_q.delete();
    endtask

    task automatic push(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = w;
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Bounded wait for frame_done or underflow; an expired bound is a failure.
    task automatic wait_end(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0 || uf_cnt > 0) break;
            tick(1);
        end
        check(tag, 32'(done_cnt > 0 || uf_cnt > 0), 32'd1);
        tick(2);
    endtask

    task automatic wait_rd(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rd_cnt >= target) break;
            tick(1);
        end
        check(tag, 32'(rd_cnt >= target), 32'd1);
    endtask

    task automatic wait_rise(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rise_cnt >= target) break;
            tick(1);
        end
        check(tag, 32'(rise_cnt >= target), 32'd1);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; stall = 1'b0;
        clear_mon();
        tick(3);
        check("rst_rd_en",  32'(fifo_rd_en), 32'd0);
        check("rst_sclk",   32'(led_sclk),   32'd0);
        check("rst_sdo",    32'(led_sdo),    32'd0);
        check("rst_latch",  32'(led_latch),  32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_done",   32'(frame_done), 32'd0);
        check("rst_uflow",  32'(underflow),  32'd0);
        rst = 1'b0;
        tick(2);

        // Full frame of pure red
        clear_mon();
        push(24'hFF0000, 40);
        start_frame();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_end("full_end", 4000);
        check("full_rd_pulses",  32'(rd_cnt),      32'd40);
        check("full_sclk_rises", 32'(rise_cnt),    32'd320);
        check("full_sdo_ones",   32'(ones_cnt),    32'd320);
        check("full_latch_len",  32'(latch_cnt),   32'd8);
        check("full_frame_cost", 32'(done_cyc - busy_rise + 1), 32'd2649);
        check("full_no_uflow",   32'(uf_cnt),      32'd0);
        check("full_no_overlap", 32'(overlap_cnt), 32'd0);
        check("full_busy_drop",  32'(busy),        32'd0);

        // Max-channel selection and bit order
        clear_mon();
`ifdef LED_GAMMA_EN
        push(24'h000080, 1);
        push(24'h0000FF, 1);
`else
        push(24'h123456, 1);
        push(24'h80FF01, 1);
`endif
        push(24'h000000, 38);
        start_frame();
        wait_end("order_end", 4000);
        check("order_nbytes", 32'(bytes_q.size()), 32'd40);
`ifdef LED_GAMMA_EN
        check("gamma_0x80", 32'(bytes_q[0]), 32'h38);
        check("gamma_0xff", 32'(bytes_q[1]), 32'hFF);
`else
        check("order_0x123456", 32'(bytes_q[0]), 32'h56);
        check("order_0x80ff01", 32'(bytes_q[1]), 32'hFF);
`endif
        check("order_last_zero", 32'(bytes_q[39]), 32'h00);

        // Stall before zone 11 shorter than the timeout
        clear_mon();
        push(24'h00FF00, 40);
        start_frame();
        wait_rd("stall_reach_z10", 11, 2000);
        stall = 1'b1;
        tick(150);
        stall = 1'b0;
        wait_end("stall_end", 4000);
        check("stall_no_uflow", 32'(uf_cnt),   32'd0);
        check("stall_done",     32'(done_cnt), 32'd1);
        check("stall_rd",       32'(rd_cnt),   32'd40);
        check("stall_latch",    32'(latch_cnt), 32'd8);

        // Timeout: only 5 words available
        clear_mon();
        push(24'h0000FF, 5);
        start_frame();
        wait_end("to_end", 3000);
        check("to_uflow_once", 32'(uf_cnt),    32'd1);
        check("to_uflow_time", 32'(uf_cyc - busy_rise), 32'd1354);
        check("to_no_latch",   32'(latch_cnt), 32'd0);
        check("to_no_done",    32'(done_cnt),  32'd0);
        check("to_rd",         32'(rd_cnt),    32'd5);
        check("to_busy_drop",  32'(busy),      32'd0);

        // frame_start during SHIFT is ignored
        clear_mon();
        push(24'h0000FF, 40);
        start_frame();
        wait_rise("ign_mid_shift", 4, 200);
        start_frame();
        wait_end("ign_end", 4000);
        check("ign_rd",   32'(rd_cnt),   32'd40);
        check("ign_cost", 32'(done_cyc - busy_rise + 1), 32'd2649);
        check("ign_done", 32'(done_cnt), 32'd1);

        // Reset mid-shift, then a fresh frame from zone 0
        clear_mon();
        push(24'hFFFFFF, 40);
        start_frame();
        wait_rise("rst_mid_shift", 3, 200);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs",
              32'({fifo_rd_en, led_sclk, led_sdo, led_latch, busy, frame_done, underflow}), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        push(24'hFFFFFF, 1);
        clear_mon();
        start_frame();
        wait_end("fresh_end", 4000);
        check("fresh_rd",   32'(rd_cnt),   32'd40);
        check("fresh_cost", 32'(done_cyc - busy_rise + 1), 32'd2649);
        check("fresh_done", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
